axi_rd_arbiter_2to1: RTL
========================

Name: axi_rd_arbiter_2to1

Overview:
- Shares the single AXI4 read path to DDR between two requesters: host DMA (port 0) and the Fletcher kernel master (port 1).
- Arbitrates the AR channel round-robin and tags each request's ID with the source index.
- Routes R beats back to their requester by that tag, and caps outstanding bursts per requester.
- Sits between the PCIS/Fletcher masters and the DDR-facing AXI bus, in the bcd_clk domain.

Parameters:
- ADDR_WIDTH, 64, address width on all AR channels.
- DATA_WIDTH, 512, R data width.
- ID_WIDTH, 6, requester-side ID width; downstream ID is ID_WIDTH+1.
- LEN_WIDTH, 8, arlen width.
- MAX_OUTSTANDING, 16, maximum accepted-but-incomplete bursts per requester (1..255).

Ports:
- bcd_clk  in  1  clock
- bcd_reset  in  1  asynchronous, active-high reset
- sN_arvalid/sN_arready  in/out  1  requester N AR handshake (N=0,1)
- sN_araddr  in  ADDR_WIDTH  requester N address
- sN_arid  in  ID_WIDTH  requester N ID
- sN_arlen  in  LEN_WIDTH  burst length-1
- sN_arsize  in  3  beat size
- sN_rvalid/sN_rready  out/in  1  requester N R handshake
- sN_rdata  out  DATA_WIDTH  read data
- sN_rid  out  ID_WIDTH  returned ID (tag stripped)
- sN_rresp  out  2  response
- sN_rlast  out  1  last beat
- m_arvalid/m_arready  out/in  1  downstream AR handshake
- m_araddr  out  ADDR_WIDTH  downstream address
- m_arid  out  ID_WIDTH+1  {source index, original ID}
- m_arlen  out  LEN_WIDTH  burst length-1
- m_arsize  out  3  beat size
- m_rvalid/m_rready  in/out  1  downstream R handshake
- m_rdata  in  DATA_WIDTH  read data
- m_rid  in  ID_WIDTH+1  tagged ID
- m_rresp  in  2  response
- m_rlast  in  1  last beat

Behaviour:
- Reset (async assert, sync release):
  - All valid/ready outputs 0, AR output register empty.
  - Both outstanding counters 0.
  - last_grant=1, so port 0 wins the first contention.
- AR stage is one output register (IDLE/HELD):
  - IDLE: eligible requesters are those with arvalid=1 and count<MAX_OUTSTANDING. With both eligible, grant !last_grant; with one eligible, grant it.
  - On grant: sN_arready=1 for that port only, in the same cycle. Capture fields into the output register, set m_arid MSB=N, update last_grant=N, go to HELD.
  - HELD: m_arvalid=1, fields stable until m_arready.
  - On m_arready, return to IDLE; a new grant may be issued in that same cycle (bypass), giving 1 request/cycle throughput.
  - Latency sN_arvalid -> m_arvalid is 1 cycle.
  - sN_arready is never asserted for an ineligible port.
- Outstanding counters:
  - countN increments on the sN AR handshake.
  - countN decrements on m_rvalid&m_rready&m_rlast with m_rid MSB=N.
  - Both in the same cycle: count unchanged.
  - Counter never wraps; a decrement at 0 is a protocol violation, flagged only by assertion.
- R routing (combinational, zero latency):
  - sel=m_rid[ID_WIDTH]; s{sel}_rvalid=m_rvalid; the other port's rvalid=0.
  - m_rready=s{sel}_rready.
  - rdata/rresp/rlast broadcast to both ports; rid = m_rid[ID_WIDTH-1:0].
- A requester with rready low stalls only the R bus; AR arbitration continues while counters permit.
- Reset mid-burst drops all state; requesters must also be reset.

Optional Feature:
- Macro AXI_RD_ARB_PERF_EN.
- When defined: adds outputs perf_grant0, perf_grant1, perf_stall (32 bits each).
  - perf_grantN counts AR grants to port N.
  - perf_stall counts cycles where some arvalid=1 but no grant was issued.
  - All three saturate at 0xFFFFFFFF and reset to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then both ports assert arvalid continuously with m_arready=1 -> grants alternate 0,1,0,1; m_arid MSB matches; first grant goes to port 0.
- Port 1 issues 16 bursts (MAX_OUTSTANDING=16) with R withheld -> 17th not accepted (s1_arready=0) while port 0 is still granted; after one rlast to port 1, the next port 1 AR is accepted the following cycle.
- m_arready=0 for 5 cycles with a held request -> m_araddr/m_arid/m_arlen stable; no further sN_arready until the handshake.
- Interleaved R beats m_rid=7'h45 then 7'h03 -> beat 1 on s1 with rid 6'h05, beat 2 on s0 with rid 6'h03; the other port's rvalid=0 in each cycle.
- AR handshake and rlast for port 0 in the same cycle, count0=3 -> count0 remains 3.
- bcd_reset asserted mid-burst -> all valid outputs 0 within the same cycle; counters return to 0.

Source files
------------

// File: rtl/axi_rd_arbiter_2to1.sv
// Two-port AXI4 read arbiter: round-robin AR with source tag in the ID MSB, R routed back by tag.
// Optional perf counters are compiled in when AXI_RD_ARB_PERF_EN is defined.
module axi_rd_arbiter_2to1 #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 6,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  bcd_clk,
    input  logic                  bcd_reset,
`ifdef AXI_RD_ARB_PERF_EN
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_stall,
`endif
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [LEN_WIDTH-1:0]  s0_arlen,
    input  logic [2:0]            s0_arsize,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [LEN_WIDTH-1:0]  s1_arlen,
    input  logic [2:0]            s1_arsize,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [ID_WIDTH:0]     m_arid,
    output logic [LEN_WIDTH-1:0]  m_arlen,
    output logic [2:0]            m_arsize,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [ID_WIDTH:0]     m_rid,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast
);

    localparam logic [7:0] CNT_MAX = 8'(MAX_OUTSTANDING);

    typedef enum logic {AR_IDLE, AR_HELD} ar_state_t;

    ar_state_t             state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [ID_WIDTH:0]     ar_id_q, ar_id_d;
    logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [7:0]            count0_q, count0_d;
    logic [7:0]            count1_q, count1_d;

    logic can_take, elig0, elig1, grant0, grant1;
    logic r_sel, rlast_fire, dec0, dec1;

    // The output register can take a new request when empty or when it drains this cycle.
    always_comb begin
        can_take = (state_q == AR_IDLE) || m_arready;
        elig0    = s0_arvalid && (count0_q < CNT_MAX);
        elig1    = s1_arvalid && (count1_q < CNT_MAX);
        grant0   = !bcd_reset && can_take && elig0 && (!elig1 || last_grant_q);
        grant1   = !bcd_reset && can_take && elig1 && (!elig0 || !last_grant_q);
    end

    assign s0_arready = grant0;
    assign s1_arready = grant1;
    assign m_arvalid  = (state_q == AR_HELD);
    assign m_araddr   = ar_addr_q;
    assign m_arid     = ar_id_q;
    assign m_arlen    = ar_len_q;
    assign m_arsize   = ar_size_q;

    always_comb begin
        r_sel      = m_rid[ID_WIDTH];
        s0_rvalid  = !bcd_reset && m_rvalid && !r_sel;
        s1_rvalid  = !bcd_reset && m_rvalid && r_sel;
        m_rready   = !bcd_reset && (r_sel ? s1_rready : s0_rready);
        rlast_fire = m_rvalid && m_rready && m_rlast;
        dec0       = rlast_fire && !r_sel;
        dec1       = rlast_fire && r_sel;
    end

    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rlast = m_rlast;
    assign s0_rid   = m_rid[ID_WIDTH-1:0];
    assign s1_rid   = m_rid[ID_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_addr_d    = ar_addr_q;
        ar_id_d      = ar_id_q;
        ar_len_d     = ar_len_q;
        ar_size_d    = ar_size_q;
        if (grant0) begin
            state_d      = AR_HELD;
            last_grant_d = 1'b0;
            ar_addr_d    = s0_araddr;
            ar_id_d      = {1'b0, s0_arid};
            ar_len_d     = s0_arlen;
            ar_size_d    = s0_arsize;
        end else if (grant1) begin
            state_d      = AR_HELD;
            last_grant_d = 1'b1;
            ar_addr_d    = s1_araddr;
            ar_id_d      = {1'b1, s1_arid};
            ar_len_d     = s1_arlen;
            ar_size_d    = s1_arsize;
        end else if (state_q == AR_HELD && m_arready) begin
            state_d = AR_IDLE;
        end
    end

    // A simultaneous accept and completion leaves the count unchanged; it never wraps below 0.
    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (grant0 && !dec0)
            count0_d = count0_q + 8'd1;
        else if (dec0 && !grant0 && count0_q != 8'd0)
            count0_d = count0_q - 8'd1;
        if (grant1 && !dec1)
            count1_d = count1_q + 8'd1;
        else if (dec1 && !grant1 && count1_q != 8'd0)
            count1_d = count1_q - 8'd1;
    end

    always_ff @(posedge bcd_clk or posedge bcd_reset) begin
        if (bcd_reset) begin
            state_q      <= AR_IDLE;
            last_grant_q <= 1'b1;
            ar_addr_q    <= '0;
            ar_id_q      <= '0;
            ar_len_q     <= '0;
            ar_size_q    <= '0;
            count0_q     <= '0;
            count1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_addr_q    <= ar_addr_d;
            ar_id_q      <= ar_id_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            count0_q     <= count0_d;
            count1_q     <= count1_d;
        end
    end

    no_underflow0: assert property (@(posedge bcd_clk) disable iff (bcd_reset)
        !(dec0 && !grant0 && count0_q == 8'd0));
    no_underflow1: assert property (@(posedge bcd_clk) disable iff (bcd_reset)
        !(dec1 && !grant1 && count1_q == 8'd0));

`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant0_d;
    logic [31:0] perf_grant1_q, perf_grant1_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_grant0_d = perf_grant0_q;
        perf_grant1_d = perf_grant1_q;
        perf_stall_d  = perf_stall_q;
        if (grant0 && perf_grant0_q != 32'hFFFF_FFFF)
            perf_grant0_d = perf_grant0_q + 32'd1;
        if (grant1 && perf_grant1_q != 32'hFFFF_FFFF)
            perf_grant1_d = perf_grant1_q + 32'd1;
        if ((s0_arvalid || s1_arvalid) && !grant0 && !grant1 && perf_stall_q != 32'hFFFF_FFFF)
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge bcd_clk or posedge bcd_reset) begin
        if (bcd_reset) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grant0_q <= perf_grant0_d;
            perf_grant1_q <= perf_grant1_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
